// File: rtl/cpu_monitor_if.sv
// Observation bus between the cpu core and the debug monitor.
// It carries the regfile request/grant handshake and the data-memory write events.
interface cpu_monitor_if;
    logic        mon_regfile_request;
    logic [3:0]  mon_regfile_ra;
    logic        mon_regfile_grant;
    logic [15:0] mon_regfile_rd;
    logic        mon_memupdate;
    logic [7:0]  mon_memaddr;
    logic [15:0] mon_memdata;

    modport master (
        input  mon_regfile_request, mon_regfile_ra,
        output mon_regfile_grant, mon_regfile_rd,
        output mon_memupdate, mon_memaddr, mon_memdata
    );

    modport slave (
        output mon_regfile_request, mon_regfile_ra,
        input  mon_regfile_grant, mon_regfile_rd,
        input  mon_memupdate, mon_memaddr, mon_memdata
    );
endinterface

// File: rtl/cpu_monitor.sv
// Debug monitor for the cpu core. It keeps a shadow copy of the 16 registers by continuous
// request/grant scanning, and it queues memory-write events in a small FIFO for the display.
module cpu_monitor #(
    parameter int TIMEOUT  = 64,
    parameter int EV_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    cpu_monitor_if.slave                mon,
    input  logic                        scan_en,
    input  logic [3:0]                  sel_reg,
    output logic [15:0]                 sel_data,
    output logic                        sel_valid,
    output logic                        scan_done,
    output logic                        ev_valid,
    output logic [7:0]                  ev_addr,
    output logic [15:0]                 ev_data,
    input  logic                        ev_pop,
    output logic [$clog2(EV_DEPTH):0]   ev_count,
    output logic                        ev_overflow,
    input  logic                        ev_clear
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int AW = $clog2(EV_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_REL = 2'd2} state_t;

    state_t         r_state, w_next_state;
    logic           r_grant_q, r_mem_q;
    logic           r_request, r_scan_done, r_sel_valid;
    logic [3:0]     r_ra, r_index;
    logic [TW-1:0]  r_timer;
    logic [15:0]    r_shadow [16];
    logic [15:0]    r_valid;
    logic [15:0]    r_sel_data;

    logic           w_grant_rise, w_mem_rise;
    logic           w_capture, w_timeout, w_issue, w_advance;
    logic           w_request_nxt, w_scan_done_nxt;
    logic [3:0]     w_index_nxt, w_ra_nxt;
    logic [TW-1:0]  w_timer_nxt;
    logic           w_sel_hit;

    assign w_grant_rise = mon.mon_regfile_grant & ~r_grant_q;
    assign w_mem_rise   = mon.mon_memupdate & ~r_mem_q;
    assign w_sel_hit    = (sel_reg == r_index);

    // Scan FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Scan FSM next-state and handshake events
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_issue      = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (scan_en) begin
                    w_issue      = 1'b1;
                    w_next_state = S_REQ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ: begin
                if (w_grant_rise) begin
                    w_capture    = 1'b1;
                    w_next_state = S_REL;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_REL;
                end else begin
                    w_next_state = S_REQ;
                end
            end
            S_REL: begin
                // The cpu must drop grant before the next request, so grants never merge.
                if (!mon.mon_regfile_grant) begin
                    w_advance = 1'b1;
                    if (scan_en) begin
                        w_issue      = 1'b1;
                        w_next_state = S_REQ;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_REL;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Scan FSM outputs: next values of the registered handshake signals
    always_comb begin
        w_index_nxt     = w_advance ? (r_index + 4'd1) : r_index;
        w_ra_nxt        = w_issue ? w_index_nxt : r_ra;
        w_timer_nxt     = r_timer;
        w_request_nxt   = r_request;
        w_scan_done_nxt = (w_capture | w_timeout) & (r_index == 4'd15);
        if (w_issue) begin
            w_request_nxt = 1'b1;
            w_timer_nxt   = '0;
        end else if (w_capture | w_timeout) begin
            w_request_nxt = 1'b0;
        end else if (r_state == S_REQ) begin
            w_timer_nxt = r_timer + TW'(1);
        end else begin
            w_timer_nxt = r_timer;
        end
    end

    // Handshake registers, shadow array and selected-register view
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_q   <= 1'b0;
            r_request   <= 1'b0;
            r_ra        <= 4'd0;
            r_index     <= 4'd0;
            r_timer     <= '0;
            r_scan_done <= 1'b0;
            r_valid     <= 16'h0000;
            r_sel_data  <= 16'h0000;
            r_sel_valid <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= 16'h0000;
            end
        end else begin
            r_grant_q   <= mon.mon_regfile_grant;
            r_request   <= w_request_nxt;
            r_ra        <= w_ra_nxt;
            r_index     <= w_index_nxt;
            r_timer     <= w_timer_nxt;
            r_scan_done <= w_scan_done_nxt;
            if (w_capture) begin
                r_shadow[r_index] <= mon.mon_regfile_rd;
                r_valid[r_index]  <= 1'b1;
            end else if (w_timeout) begin
                r_valid[r_index]  <= 1'b0;
            end
            // Bypass so a capture to the selected entry shows up without an extra cycle.
            if (w_capture && w_sel_hit) begin
                r_sel_data  <= mon.mon_regfile_rd;
                r_sel_valid <= 1'b1;
            end else if (w_timeout && w_sel_hit) begin
                r_sel_data  <= r_shadow[sel_reg];
                r_sel_valid <= 1'b0;
            end else begin
                r_sel_data  <= r_shadow[sel_reg];
                r_sel_valid <= r_valid[sel_reg];
            end
        end
    end

    assign mon.mon_regfile_request = r_request;
    assign mon.mon_regfile_ra      = r_ra;
    assign sel_data                = r_sel_data;
    assign sel_valid               = r_sel_valid;
    assign scan_done               = r_scan_done;

    logic [7:0]     r_fifo_addr [EV_DEPTH];
    logic [15:0]    r_fifo_data [EV_DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;
    logic           w_pop_ok, w_full, w_push_ok;

    assign w_pop_ok  = ev_pop && (r_count != CW'(0));
    assign w_full    = (r_count == CW'(EV_DEPTH));
    assign w_push_ok = w_mem_rise && (!w_full || w_pop_ok);

    // Memory-event FIFO; clear wins over any same-cycle push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_q    <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < EV_DEPTH; i++) begin
                r_fifo_addr[i] <= 8'h00;
                r_fifo_data[i] <= 16'h0000;
            end
        end else begin
            r_mem_q <= mon.mon_memupdate;
            if (ev_clear) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push_ok) begin
                    r_fifo_addr[r_wr_ptr] <= mon.mon_memaddr;
                    r_fifo_data[r_wr_ptr] <= mon.mon_memdata;
                    r_wr_ptr              <= r_wr_ptr + AW'(1);
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_mem_rise && !w_push_ok) begin
                    r_overflow <= 1'b1;
                end
                case ({w_push_ok, w_pop_ok})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign ev_valid    = (r_count != CW'(0));
    assign ev_addr     = ev_valid ? r_fifo_addr[r_rd_ptr] : 8'h00;
    assign ev_data     = ev_valid ? r_fifo_data[r_rd_ptr] : 16'h0000;
    assign ev_count    = r_count;
    assign ev_overflow = r_overflow;
endmodule

// File: tb/tb_cpu_monitor.sv
// Directed bench for cpu_monitor: a small cpu regfile responder plus a linear check sequence.
module tb_cpu_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en, ev_pop, ev_clear;
    logic [3:0]  sel_reg;
    logic [15:0] sel_data, ev_data;
    logic        sel_valid, scan_done, ev_valid, ev_overflow;
    logic [7:0]  ev_addr;
    logic [2:0]  ev_count;

    int checks = 0;
    int failures = 0;
    int skip_idx = -1;
    int hold_cycles = 0;
    int gcnt = 0;
    int hold_left = 0;

    always #5 clk = ~clk;

    cpu_monitor_if u_if();

    cpu_monitor #(.TIMEOUT(64), .EV_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .mon(u_if.slave), .scan_en(scan_en),
        .sel_reg(sel_reg), .sel_data(sel_data), .sel_valid(sel_valid), .scan_done(scan_done),
        .ev_valid(ev_valid), .ev_addr(ev_addr), .ev_data(ev_data), .ev_pop(ev_pop),
        .ev_count(ev_count), .ev_overflow(ev_overflow), .ev_clear(ev_clear)
    );

    // cpu responder: grant 3 negedges after request, register k reads 16'h1000+k
    always @(negedge clk) begin
        if (rst) begin
            u_if.mon_regfile_grant = 1'b0;
            u_if.mon_regfile_rd    = 16'h0000;
            gcnt = 0;
            hold_left = 0;
        end else if (u_if.mon_regfile_grant) begin
            if (hold_left > 0) begin
                hold_left--;
                u_if.mon_regfile_rd = 16'hBEEF;
            end else if (!u_if.mon_regfile_request) begin
                u_if.mon_regfile_grant = 1'b0;
            end
        end else if (u_if.mon_regfile_request && int'(u_if.mon_regfile_ra) != skip_idx) begin
            gcnt++;
            if (gcnt == 3) begin
                u_if.mon_regfile_grant = 1'b1;
                u_if.mon_regfile_rd    = 16'h1000 + {12'h000, u_if.mon_regfile_ra};
                gcnt = 0;
                hold_left = hold_cycles;
            end
        end else begin
            gcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mem_event(input logic [7:0] a, input logic [15:0] d, input logic pop, input logic clr);
        u_if.mon_memupdate = 1'b1;
        u_if.mon_memaddr   = a;
        u_if.mon_memdata   = d;
        ev_pop   = pop;
        ev_clear = clr;
        step(1);
        u_if.mon_memupdate = 1'b0;
        ev_pop   = 1'b0;
        ev_clear = 1'b0;
        step(1);
    endtask

    task automatic pop1();
        ev_pop = 1'b1;
        step(1);
        ev_pop = 1'b0;
    endtask

    task automatic clr1();
        ev_clear = 1'b1;
        step(1);
        ev_clear = 1'b0;
    endtask

    initial begin
        int found;
        int cnt;
        int viol;
        logic [3:0] hk;
        logic [3:0] exp_ra;

        rst = 1'b1; scan_en = 1'b0; sel_reg = 4'd0; ev_pop = 1'b0; ev_clear = 1'b0;
        u_if.mon_memupdate = 1'b0; u_if.mon_memaddr = 8'h00; u_if.mon_memdata = 16'h0000;
        step(3);
        chk("rst_request", u_if.mon_regfile_request, 1'b0);
        chk("rst_ra", u_if.mon_regfile_ra, 4'd0);
        chk("rst_sel_data", sel_data, 16'h0000);
        chk("rst_sel_valid", sel_valid, 1'b0);
        chk("rst_scan_done", scan_done, 1'b0);
        chk("rst_ev_valid", ev_valid, 1'b0);
        chk("rst_ev_count", ev_count, 3'd0);
        chk("rst_ev_overflow", ev_overflow, 1'b0);
        chk("rst_ev_addr", ev_addr, 8'h00);
        rst = 1'b0;
        step(2);
        chk("idle_no_request", u_if.mon_regfile_request, 1'b0);

        // full scan passes
        scan_en = 1'b1;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            step(1);
            if (scan_done) found = 1;
        end
        chk("first_scan_done", found, 1);
        step(1);
        chk("scan_done_width", scan_done, 1'b0);
        cnt = 1;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            if (scan_done) found = 1;
            else begin
                step(1);
                cnt++;
            end
        end
        chk("pass_period", cnt, 64);
        for (int k = 0; k < 16; k++) begin
            sel_reg = 4'(k);
            step(1);
            chk("shadow_data", sel_data, 16'h1000 + 16'(k));
            chk("shadow_valid", sel_valid, 1'b1);
        end
        sel_reg = 4'd5;
        step(1);
        chk("sel5_data", sel_data, 16'h1005);

        // no grant for register 2
        skip_idx = 2;
        sel_reg = 4'd2;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (u_if.mon_regfile_request && u_if.mon_regfile_ra == 4'd2) found = 1;
            else step(1);
        end
        chk("wait_req2", found, 1);
        cnt = 0;
        while (u_if.mon_regfile_request && u_if.mon_regfile_ra == 4'd2 && cnt < 200) begin
            cnt++;
            step(1);
        end
        chk("timeout_len", cnt, 64);
        step(1);
        chk("timeout_valid2", sel_valid, 1'b0);
        chk("timeout_keep_data2", sel_data, 16'h1002);
        skip_idx = -1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (u_if.mon_regfile_request) found = 1;
            else step(1);
        end
        chk("after_timeout_req", found, 1);
        chk("after_timeout_ra", u_if.mon_regfile_ra, 4'd3);

        // grant held high for 10 cycles after its rising edge
        hold_cycles = 10;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            if (u_if.mon_regfile_grant) found = 1;
            else step(1);
        end
        chk("wait_hold_grant", found, 1);
        hold_cycles = 0;
        hk = u_if.mon_regfile_ra;
        viol = 0;
        cnt = 0;
        while (u_if.mon_regfile_grant && cnt < 40) begin
            if (u_if.mon_regfile_request) viol++;
            cnt++;
            step(1);
        end
        chk("hold_no_request", viol, 0);
        chk("hold_grant_fell", u_if.mon_regfile_grant, 1'b0);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (u_if.mon_regfile_request) found = 1;
            else step(1);
        end
        exp_ra = hk + 4'd1;
        chk("hold_reissue", found, 1);
        chk("hold_next_ra", u_if.mon_regfile_ra, exp_ra);
        sel_reg = hk;
        step(1);
        chk("hold_single_capture", sel_data, 16'h1000 + {12'h000, hk});

        // event FIFO: overflow and ordering
        clr1();
        for (int i = 0; i < 5; i++) mem_event(8'h10 + 8'(i), 16'h00A0 + 16'(i), 1'b0, 1'b0);
        chk("ev_full_count", ev_count, 3'd4);
        chk("ev_overflow_set", ev_overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("ev_pop_addr", ev_addr, 8'h10 + 8'(i));
            chk("ev_pop_data", ev_data, 16'h00A0 + 16'(i));
            pop1();
        end
        chk("ev_drained_count", ev_count, 3'd0);
        chk("ev_drained_valid", ev_valid, 1'b0);
        chk("ev_empty_addr", ev_addr, 8'h00);
        chk("ev_overflow_sticky", ev_overflow, 1'b1);
        pop1();
        chk("ev_pop_empty", ev_count, 3'd0);
        clr1();
        chk("ev_clear_overflow", ev_overflow, 1'b0);

        // push+pop while full, clear vs push, push+pop while empty
        for (int i = 0; i < 4; i++) mem_event(8'h20 + 8'(i), 16'h00B0 + 16'(i), 1'b0, 1'b0);
        mem_event(8'h24, 16'h00B4, 1'b1, 1'b0);
        chk("full_pushpop_count", ev_count, 3'd4);
        chk("full_pushpop_ovf", ev_overflow, 1'b0);
        chk("full_pushpop_head", ev_addr, 8'h21);
        for (int i = 0; i < 3; i++) pop1();
        chk("new_tail_addr", ev_addr, 8'h24);
        chk("new_tail_data", ev_data, 16'h00B4);
        for (int i = 0; i < 4; i++) mem_event(8'h25 + 8'(i), 16'h00B5 + 16'(i), 1'b0, 1'b0);
        chk("refill_count", ev_count, 3'd4);
        chk("refill_overflow", ev_overflow, 1'b1);
        mem_event(8'h29, 16'h00B9, 1'b0, 1'b1);
        chk("clear_push_count", ev_count, 3'd0);
        chk("clear_push_ovf", ev_overflow, 1'b0);
        chk("clear_push_valid", ev_valid, 1'b0);
        mem_event(8'h30, 16'h00C0, 1'b1, 1'b0);
        chk("empty_pushpop_count", ev_count, 3'd1);
        chk("empty_pushpop_addr", ev_addr, 8'h30);
        chk("empty_pushpop_data", ev_data, 16'h00C0);

        // reset in the middle of a request
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (u_if.mon_regfile_request) found = 1;
            else step(1);
        end
        chk("wait_req_for_rst", found, 1);
        rst = 1'b1;
        #1;
        chk("rst_drops_request", u_if.mon_regfile_request, 1'b0);
        scan_en = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        viol = 0;
        for (int k = 0; k < 16; k++) begin
            sel_reg = 4'(k);
            step(1);
            if (sel_valid !== 1'b0) viol++;
        end
        chk("rst_valid_cleared", viol, 0);
        chk("rst_fifo_empty", ev_count, 3'd0);
        scan_en = 1'b1;
        step(1);
        chk("restart_request", u_if.mon_regfile_request, 1'b1);
        chk("restart_ra", u_if.mon_regfile_ra, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
